// File: rtl/top_gate_unit.sv
// Two-input gate cell: each async pin is synchronized and optionally debounced,
// then a 4-entry truth table drives one registered output.

module top_gate_unit_lane #(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_lvl
);

  logic r_s1, r_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      // Without debouncing the filtered level is the synchronizer output itself,
      // so the path stays at three edges: s1, s2, out.
      assign o_lvl = r_s2;
    end else begin : g_db
      localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic             r_f;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_f   <= 1'b0;
          r_cnt <= '0;
        end else if (r_s2 == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
          r_f   <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_lvl = r_f;
    end
  endgenerate

endmodule

module top_gate_unit #(
  parameter logic [3:0] FUNC            = 4'b1000,
  parameter int         DEBOUNCE_CYCLES = 0,
  parameter int         CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_1,
  input  logic in_0,
  output logic out_0
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] w_in;
  logic [NUM_LANES-1:0] w_lvl;
  logic                 r_out;

  assign w_in = {in_1, in_0};

  top_gate_unit_lane #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (w_in),
    .o_lvl (w_lvl)
  );

  // Lane 1 is the MSB of the truth-table index.
  always_ff @(posedge clk) begin
    if (!rst_n) r_out <= 1'b0;
    else        r_out <= FUNC[w_lvl];
  end

  assign out_0 = r_out;

endmodule

// File: tb/tb_top_gate_unit.sv
// Directed bench for top_gate_unit: AND, XOR and debounced (D=4) instances
// share clock, reset and inputs.

module tb_top_gate_unit;

  logic clk, rst_n, in_1, in_0;
  logic out_and, out_xor, out_db;
  int   checks = 0;
  int   errors = 0;

  top_gate_unit u_and (
    .clk(clk), .rst_n(rst_n), .in_1(in_1), .in_0(in_0), .out_0(out_and)
  );

  top_gate_unit #(.FUNC(4'b0110)) u_xor (
    .clk(clk), .rst_n(rst_n), .in_1(in_1), .in_0(in_0), .out_0(out_xor)
  );

  top_gate_unit #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) u_db (
    .clk(clk), .rst_n(rst_n), .in_1(in_1), .in_0(in_0), .out_0(out_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_1 = 1'b1; in_0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_and !== 1'b0) begin
        errors++; $display("FAIL reset_hold_and edge%0d: got %b want 0", i, out_and);
      end
      checks++;
      if (out_db !== 1'b0) begin
        errors++; $display("FAIL reset_hold_db edge%0d: got %b want 0", i, out_db);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      logic exp;
      tick();
      exp = (e == 3);
      checks++;
      if (out_and !== exp) begin
        errors++; $display("FAIL reset_release edge%0d: got %b want %b", e, out_and, exp);
      end
    end
  endtask

  task automatic test_truth_table;
    logic [1:0] vec   [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic       e_and [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       e_xor [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       p_and, p_xor, xa, xx;
    p_and = 1'b1;  // inputs were 11 coming out of reset
    p_xor = 1'b0;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk) {in_1, in_0} = vec[v];
      for (int e = 0; e < 5; e++) begin
        tick();
        xa = (e >= 2) ? e_and[v] : p_and;
        xx = (e >= 2) ? e_xor[v] : p_xor;
        checks++;
        if (out_and !== xa) begin
          errors++; $display("FAIL tt_and in=%b edge%0d: got %b want %b", vec[v], e, out_and, xa);
        end
        checks++;
        if (out_xor !== xx) begin
          errors++; $display("FAIL tt_xor in=%b edge%0d: got %b want %b", vec[v], e, out_xor, xx);
        end
      end
      p_and = e_and[v];
      p_xor = e_xor[v];
    end
  endtask

  task automatic test_latency;
    logic exp;
    @(negedge clk) begin in_1 = 1'b1; in_0 = 1'b0; end
    repeat (5) tick();
    checks++;
    if (out_and !== 1'b0) begin
      errors++; $display("FAIL latency_pre: got %b want 0", out_and);
    end
    @(negedge clk) in_0 = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      exp = (e == 2);
      checks++;
      if (out_and !== exp) begin
        errors++; $display("FAIL latency edge N+%0d: got %b want %b", e, out_and, exp);
      end
    end
  endtask

  task automatic test_debounce;
    logic exp;
    @(negedge clk) begin in_1 = 1'b1; in_0 = 1'b0; end
    repeat (12) tick();
    checks++;
    if (out_db !== 1'b0) begin
      errors++; $display("FAIL db_settle: got %b want 0", out_db);
    end
    // 3-cycle glitch is shorter than D=4 and must be rejected
    @(negedge clk) in_0 = 1'b1;
    repeat (3) tick();
    @(negedge clk) in_0 = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (out_db !== 1'b0) begin
        errors++; $display("FAIL db_glitch edge%0d: got %b want 0", e, out_db);
      end
    end
    @(negedge clk) in_0 = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp = (e >= 6);
      checks++;
      if (out_db !== exp) begin
        errors++; $display("FAIL db_hold edge N+%0d: got %b want %b", e, out_db, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce;
    logic exp;
    @(negedge clk) in_0 = 1'b0;
    repeat (12) tick();
    checks++;
    if (out_db !== 1'b0) begin
      errors++; $display("FAIL mid_settle: got %b want 0", out_db);
    end
    @(negedge clk) in_0 = 1'b1;
    repeat (4) tick();  // counter now at 2
    @(negedge clk) rst_n = 1'b0;
    tick();
    checks++;
    if (out_db !== 1'b0) begin
      errors++; $display("FAIL mid_reset_db: got %b want 0", out_db);
    end
    checks++;
    if (out_and !== 1'b0) begin
      errors++; $display("FAIL mid_reset_and: got %b want 0", out_and);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e >= 7);
      checks++;
      if (out_db !== exp) begin
        errors++; $display("FAIL mid_restart edge R+%0d: got %b want %b", e, out_db, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_latency();
    test_debounce();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
